id_ex_stage: RTL and testbench

//  Decode-to-execute pipeline register of the 16-bit datapath. Captures the operands

---
 rtl/id_ex_stage.sv | 127 ++++++++++++
 tb/tb_id_ex_stage.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// id_ex_stage -- decode-to-execute pipeline register of the 16-bit datapath.
//
// Captures register-file operands (R1, R2 and R15 at index 0) together with the
// decoded instruction fields. Writeback data that the register file does not yet
// show is bypassed into the captured operands. A load in EX whose destination
// feeds the instruction in decode raises stallReq and becomes a one-cycle bubble.
// Flush from branch resolution also bubbles EX.
//
// Ports:
//   clk, rst                 clock (rising edge), asynchronous active-low reset
//   idValid/idOpcode/idRegR1/idRegR2/idRegDst/idImm/idWrEn/idIsLoad
//                            decoded instruction presented by decode
//   rdR1/rdR2/rdR15          register file read data
//   wbWr/wbDst/wbData        writeback write of the general destination
//   wbWrR15/wbR15Data        writeback write of R15
//   flush                    discard the instruction entering EX
//   ex*                      registered EX-stage instruction and operands
//   stallReq                 combinational: hold PC and decode this cycle
module id_ex_stage #(
  parameter int regSize  = 4,
  parameter int dataSize = 16,
  parameter int opSize   = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                idValid,
  input  logic [opSize-1:0]   idOpcode,
  input  logic [regSize-1:0]  idRegR1,
  input  logic [regSize-1:0]  idRegR2,
  input  logic [regSize-1:0]  idRegDst,
  input  logic [dataSize-1:0] idImm,
  input  logic                idWrEn,
  input  logic                idIsLoad,
  input  logic [dataSize-1:0] rdR1,
  input  logic [dataSize-1:0] rdR2,
  input  logic [dataSize-1:0] rdR15,
  input  logic                wbWr,
  input  logic [regSize-1:0]  wbDst,
  input  logic [dataSize-1:0] wbData,
  input  logic                wbWrR15,
  input  logic [dataSize-1:0] wbR15Data,
  input  logic                flush,
  output logic                exValid,
  output logic [opSize-1:0]   exOpcode,
  output logic [regSize-1:0]  exDst,
  output logic                exWrEn,
  output logic                exIsLoad,
  output logic [dataSize-1:0] exOp1,
  output logic [dataSize-1:0] exOp2,
  output logic [dataSize-1:0] exR15,
  output logic [dataSize-1:0] exImm,
  output logic                stallReq
);

  typedef struct packed {
    logic                valid;
    logic [opSize-1:0]   opcode;
    logic [regSize-1:0]  dst;
    logic                wrEn;
    logic                isLoad;
    logic [dataSize-1:0] op1;
    logic [dataSize-1:0] op2;
    logic [dataSize-1:0] r15;
    logic [dataSize-1:0] imm;
  } ex_t;

  ex_t ex_q, ex_d;
  logic [dataSize-1:0] byp1, byp2, byp15;

  // Writeback bypass. A general-destination write to index 0 beats wbWrR15,
  // mirroring the register file's own write priority.
  function automatic logic [dataSize-1:0] bypass(
    input logic [regSize-1:0]  a,
    input logic [dataSize-1:0] d,
    input logic                wr,
    input logic [regSize-1:0]  dst,
    input logic [dataSize-1:0] wdat,
    input logic                wr15,
    input logic [dataSize-1:0] w15dat
  );
    if (wr && dst == a)            return wdat;
    else if (a == '0 && wr15)      return w15dat;
    else                           return d;
  endfunction

  always_comb begin
    byp1  = bypass(idRegR1, rdR1,  wbWr, wbDst, wbData, wbWrR15, wbR15Data);
    byp2  = bypass(idRegR2, rdR2,  wbWr, wbDst, wbData, wbWrR15, wbR15Data);
    byp15 = bypass('0,      rdR15, wbWr, wbDst, wbData, wbWrR15, wbR15Data);
  end

  // Load-use hazard: uses only the registered EX state and current decode,
  // so the bubble it causes clears exValid and ends the stall after one cycle.
  assign stallReq = ex_q.valid & ex_q.isLoad & ex_q.wrEn & idValid &
                    ((ex_q.dst == idRegR1) | (ex_q.dst == idRegR2));

  always_comb begin
    ex_d = '0;
    if (!flush && !stallReq) begin
      ex_d.valid  = idValid;
      ex_d.opcode = idOpcode;
      ex_d.dst    = idRegDst;
      ex_d.wrEn   = idWrEn & idValid;
      ex_d.isLoad = idIsLoad & idValid;
      ex_d.op1    = byp1;
      ex_d.op2    = byp2;
      ex_d.r15    = byp15;
      ex_d.imm    = idImm;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ex_q <= '0;
    else      ex_q <= ex_d;
  end

  assign exValid  = ex_q.valid;
  assign exOpcode = ex_q.opcode;
  assign exDst    = ex_q.dst;
  assign exWrEn   = ex_q.wrEn;
  assign exIsLoad = ex_q.isLoad;
  assign exOp1    = ex_q.op1;
  assign exOp2    = ex_q.op2;
  assign exR15    = ex_q.r15;
  assign exImm    = ex_q.imm;

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic        idValid, idWrEn, idIsLoad, wbWr, wbWrR15, flush;
  logic [3:0]  idOpcode, idRegR1, idRegR2, idRegDst, wbDst;
  logic [15:0] idImm, rdR1, rdR2, rdR15, wbData, wbR15Data;
  logic        exValid, exWrEn, exIsLoad, stallReq;
  logic [3:0]  exOpcode, exDst;
  logic [15:0] exOp1, exOp2, exR15, exImm;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst(rst),
    .idValid(idValid), .idOpcode(idOpcode), .idRegR1(idRegR1), .idRegR2(idRegR2),
    .idRegDst(idRegDst), .idImm(idImm), .idWrEn(idWrEn), .idIsLoad(idIsLoad),
    .rdR1(rdR1), .rdR2(rdR2), .rdR15(rdR15),
    .wbWr(wbWr), .wbDst(wbDst), .wbData(wbData), .wbWrR15(wbWrR15), .wbR15Data(wbR15Data),
    .flush(flush),
    .exValid(exValid), .exOpcode(exOpcode), .exDst(exDst), .exWrEn(exWrEn),
    .exIsLoad(exIsLoad), .exOp1(exOp1), .exOp2(exOp2), .exR15(exR15), .exImm(exImm),
    .stallReq(stallReq)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    idValid = 0; idOpcode = 0; idRegR1 = 0; idRegR2 = 0; idRegDst = 0; idImm = 0;
    idWrEn = 0; idIsLoad = 0; rdR1 = 0; rdR2 = 0; rdR15 = 0;
    wbWr = 0; wbDst = 0; wbData = 0; wbWrR15 = 0; wbR15Data = 0; flush = 0;
  endtask

  task automatic instr(input logic [3:0] op, input logic [3:0] r1, input logic [3:0] r2,
                       input logic [3:0] dst, input logic ld);
    idValid = 1; idOpcode = op; idRegR1 = r1; idRegR2 = r2; idRegDst = dst;
    idWrEn = 1; idIsLoad = ld;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".valid"}, {31'd0, exValid}, 0);
    chk({tag, ".wren"},  {31'd0, exWrEn}, 0);
    chk({tag, ".load"},  {31'd0, exIsLoad}, 0);
    chk({tag, ".opc"},   {28'd0, exOpcode}, 0);
    chk({tag, ".dst"},   {28'd0, exDst}, 0);
    chk({tag, ".data"},  {exOp1 | exOp2, exR15 | exImm}, 0);
    chk({tag, ".stall"}, {31'd0, stallReq}, 0);
  endtask

  initial begin
    idle();
    rst = 0;
    #2;
    chk_all_zero("por");
    #10 rst = 1;

    // Bypass of general destination into operand 1; plain reads elsewhere.
    tick();
    instr(4'h2, 4'd3, 4'd4, 4'd9, 0);
    idImm = 16'hFFF8; rdR1 = 16'hF033; rdR2 = 16'h0042; rdR15 = 16'h0F0F;
    wbWr = 1; wbDst = 4'd3; wbData = 16'h1234;
    tick();
    chk("byp.op1", exOp1, 16'h1234);
    chk("byp.op2", exOp2, 16'h0042);
    chk("byp.r15", exR15, 16'h0F0F);
    chk("byp.imm", exImm, 16'hFFF8);
    chk("byp.valid", {31'd0, exValid}, 1);

    // Index-0 priority: dst write beats wbWrR15, then wbWrR15 alone.
    idRegR1 = 4'd1; idRegR2 = 4'd0; rdR1 = 16'h1111; rdR2 = 16'hBEEF;
    wbWrR15 = 1; wbR15Data = 16'hAAAA; wbWr = 1; wbDst = 4'd0; wbData = 16'h5555;
    tick();
    chk("r15pri.op2", exOp2, 16'h5555);
    chk("r15pri.r15", exR15, 16'h5555);
    chk("r15pri.op1", exOp1, 16'h1111);
    wbWr = 0;
    tick();
    chk("r15wb.op2", exOp2, 16'hAAAA);
    chk("r15wb.r15", exR15, 16'hAAAA);
    idle();

    // Load-use stall on R2.
    instr(4'h8, 4'd0, 4'd0, 4'd5, 1);
    tick();
    chk("ld.isload", {31'd0, exIsLoad}, 1);
    chk("ld.dst", {28'd0, exDst}, 5);
    instr(4'h1, 4'd2, 4'd5, 4'd6, 0);
    #1;
    chk("lu.stall", {31'd0, stallReq}, 1);
    tick();
    chk("lu.bubble.valid", {31'd0, exValid}, 0);
    chk("lu.bubble.wren", {31'd0, exWrEn}, 0);
    chk("lu.bubble.opc", {28'd0, exOpcode}, 0);
    chk("lu.stall.clear", {31'd0, stallReq}, 0);
    tick();
    chk("lu.load.valid", {31'd0, exValid}, 1);
    chk("lu.load.opc", {28'd0, exOpcode}, 1);
    chk("lu.load.dst", {28'd0, exDst}, 6);
    chk("lu.load.stall", {31'd0, stallReq}, 0);

    // Flush together with stall: single bubble, no duplication.
    instr(4'h8, 4'd0, 4'd0, 4'd7, 1);
    tick();
    instr(4'h2, 4'd7, 4'd1, 4'd3, 0);
    flush = 1;
    #1;
    chk("fl.stall", {31'd0, stallReq}, 1);
    tick();
    chk("fl.valid", {31'd0, exValid}, 0);
    chk("fl.wren", {31'd0, exWrEn}, 0);
    flush = 0;
    instr(4'h3, 4'd1, 4'd2, 4'd4, 0);
    tick();
    chk("fl.next.opc", {28'd0, exOpcode}, 3);
    chk("fl.next.valid", {31'd0, exValid}, 1);
    instr(4'h4, 4'd1, 4'd2, 4'd4, 0);
    tick();
    chk("fl.nodup.opc", {28'd0, exOpcode}, 4);

    // Back-to-back ALU ops.
    for (int i = 0; i < 3; i++) begin
      instr(4'hA + 4'(i), 4'd1, 4'd2, 4'(i + 8), 0);
      #1;
      chk("b2b.stall", {31'd0, stallReq}, 0);
      tick();
      chk("b2b.opc", {28'd0, exOpcode}, 32'hA + 32'(i));
      chk("b2b.dst", {28'd0, exDst}, 32'(i + 8));
      chk("b2b.valid", {31'd0, exValid}, 1);
    end

    // idValid=0 still captures fields but masks wrEn/isLoad.
    instr(4'h9, 4'd1, 4'd2, 4'd5, 1);
    idValid = 0;
    tick();
    chk("inv.valid", {31'd0, exValid}, 0);
    chk("inv.wren", {31'd0, exWrEn}, 0);
    chk("inv.load", {31'd0, exIsLoad}, 0);
    chk("inv.opc", {28'd0, exOpcode}, 9);

    // Async reset during a pending stall.
    instr(4'h8, 4'd0, 4'd0, 4'd5, 1);
    tick();
    instr(4'h1, 4'd5, 4'd0, 4'd6, 0);
    #1;
    chk("rst.pre.stall", {31'd0, stallReq}, 1);
    rst = 0;
    #1;
    chk_all_zero("rst.async");
    #1 rst = 1;
    tick();
    chk("rst.first.valid", {31'd0, exValid}, 1);
    chk("rst.first.opc", {28'd0, exOpcode}, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
